// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: word type, padding constants, block count and pad-word selection.
package sha256_pkg;

    typedef logic [31:0] word_t;

    localparam word_t       PAD_MARKER      = 32'h8000_0000;
    localparam int unsigned WORDS_PER_BLOCK = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_EMIT,
        ST_PAD
    } pad_state_e;

    // Number of 512-bit blocks after appending the marker and the 64-bit length.
    function automatic int unsigned num_blocks(input int unsigned len);
        return (len + 32'd2) / WORDS_PER_BLOCK + 32'd1;
    endfunction

    // Word at global stream index n (n >= len) of the padded message.
    function automatic word_t pad_word(input int unsigned n, input int unsigned len);
        if (n == len) begin
            return PAD_MARKER;
        end else if (n == WORDS_PER_BLOCK * num_blocks(len) - 32'd1) begin
            return word_t'(len << 5);
        end
        return '0;
    endfunction

endpackage

// File: rtl/sha256_msg_padder.sv
// Reads an L-word message from 1-cycle-latency memory and streams it as padded
// SHA-256 blocks over a valid/ready interface, one word per accepted transfer.
module sha256_msg_padder
    import sha256_pkg::*;
#(
    parameter int unsigned NUM_OF_WORDS = 20
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [15:0] message_addr,
    output logic        busy,
    output logic        done,
    output logic        mem_clk,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    input  logic [31:0] mem_read_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [3:0]  out_word_idx,
    output logic [7:0]  out_block_idx,
    output logic        out_last_block
);

    localparam int unsigned MSG_LEN     = NUM_OF_WORDS;
    localparam int unsigned NUM_BLOCKS  = num_blocks(MSG_LEN);
    localparam int unsigned TOTAL_WORDS = WORDS_PER_BLOCK * NUM_BLOCKS;
    localparam int unsigned ADDR_W      = 16;
    localparam int unsigned POS_W       = 4;
    localparam int unsigned BLK_W       = 8;

    pad_state_e        state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] msg_idx_q, msg_idx_d;
    logic [POS_W-1:0]  pos_q, pos_d;
    logic [BLK_W-1:0]  blk_q, blk_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              out_valid_q, out_valid_d;
    word_t             out_data_q, out_data_d;
    logic              last_block_q, last_block_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;

    logic                   accept;
    logic [POS_W-1:0]       pos_nxt;
    logic [BLK_W-1:0]       blk_nxt;
    logic [BLK_W+POS_W-1:0] n_cur;
    logic [BLK_W+POS_W-1:0] n_nxt;

    // Next-state and output computation.
    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        msg_idx_d    = msg_idx_q;
        pos_d        = pos_q;
        blk_d        = blk_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        last_block_d = last_block_q;
        mem_addr_d   = mem_addr_q;

        accept  = out_valid_q && out_ready;
        pos_nxt = pos_q + POS_W'(1);
        blk_nxt = (pos_q == POS_W'(WORDS_PER_BLOCK - 1)) ? blk_q + BLK_W'(1) : blk_q;
        n_cur   = {blk_q, pos_q};
        n_nxt   = {blk_nxt, pos_nxt};

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    base_d       = message_addr;
                    msg_idx_d    = '0;
                    pos_d        = '0;
                    blk_d        = '0;
                    busy_d       = 1'b1;
                    mem_addr_d   = message_addr;
                    last_block_d = (NUM_BLOCKS == 32'd1);
                    state_d      = ST_REQ;
                end
            end
            ST_REQ: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                out_data_d  = mem_read_data;
                out_valid_d = 1'b1;
                state_d     = ST_EMIT;
            end
            ST_EMIT: begin
                if (accept) begin
                    msg_idx_d    = msg_idx_q + ADDR_W'(1);
                    pos_d        = pos_nxt;
                    blk_d        = blk_nxt;
                    last_block_d = (32'(blk_nxt) == NUM_BLOCKS - 32'd1);
                    if (32'(msg_idx_q) + 32'd1 < MSG_LEN) begin
                        out_valid_d = 1'b0;
                        mem_addr_d  = base_q + msg_idx_q + ADDR_W'(1);
                        state_d     = ST_REQ;
                    end else begin
                        out_data_d = pad_word(32'(n_nxt), MSG_LEN);
                        state_d    = ST_PAD;
                    end
                end
            end
            ST_PAD: begin
                if (accept) begin
                    if (32'(n_cur) == TOTAL_WORDS - 32'd1) begin
                        out_valid_d = 1'b0;
                        busy_d      = 1'b0;
                        done_d      = 1'b1;
                        state_d     = ST_IDLE;
                    end else begin
                        pos_d        = pos_nxt;
                        blk_d        = blk_nxt;
                        last_block_d = (32'(blk_nxt) == NUM_BLOCKS - 32'd1);
                        out_data_d   = pad_word(32'(n_nxt), MSG_LEN);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            base_q       <= '0;
            msg_idx_q    <= '0;
            pos_q        <= '0;
            blk_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            last_block_q <= 1'b0;
            mem_addr_q   <= '0;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            msg_idx_q    <= msg_idx_d;
            pos_q        <= pos_d;
            blk_q        <= blk_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            last_block_q <= last_block_d;
            mem_addr_q   <= mem_addr_d;
        end
    end

    assign mem_clk        = clk;
    assign mem_we         = 1'b0;
    assign mem_addr       = mem_addr_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign out_valid      = out_valid_q;
    assign out_data       = out_data_q;
    assign out_word_idx   = pos_q;
    assign out_block_idx  = blk_q;
    assign out_last_block = last_block_q;

endmodule
